// File: rtl/spi_slave_rx_if.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_if
// Valid/ready word hand-off between the SPI receive path and the core.
//
// Parameters:
//   W         word width in bits
//
// Signals:
//   rx_data   received word, first wire byte in the top byte
//   rx_valid  rx_data holds a word not yet taken by the consumer
//   rx_ready  consumer takes the word on a cycle where rx_valid && rx_ready
//
// Modports:
//   master    word producer (the SPI receiver)
//   slave     word consumer (the core)
// -----------------------------------------------------------------------------
interface spi_slave_rx_if #(
    parameter int W = 32
);
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// SPI (mode 0) target-side receive path. The SCLK, CS_N and MOSI pins are
// asynchronous to clk and are synchronized here. Bits are deserialized into
// bytes and bytes into a W = 8*BYTES_PER_WORD bit word. Each completed word is
// offered on a valid/ready interface.
//
// Parameters:
//   BYTES_PER_WORD  bytes per word (word width W = 8*BYTES_PER_WORD)
//   SYNC_STAGES     flops per input synchronizer (>= 2)
//
// Ports:
//   clk        system clock. It must run at least 4x the SCLK frequency.
//   rst        asynchronous active-high reset
//   sclk       SPI serial clock. It is asynchronous and idles low.
//   cs_n       SPI chip select. It is asynchronous and active-low.
//   mosi       SPI serial data in. It is asynchronous.
//   rx_if      master modport: rx_data / rx_valid out, rx_ready in
//   overrun    one-cycle pulse: a completed word was dropped because the
//              output buffer was still full
//   frame_err  one-cycle pulse: cs_n deasserted part way through a word
//   busy       synchronized chip select is asserted
//
// Build option:
//   SPI_SLAVE_RX_LSB_FIRST_EN  when defined, bits within each byte arrive LSB
//                              first. Byte order on the wire is unchanged.
//                              When undefined (default), bits arrive MSB first.
// -----------------------------------------------------------------------------
module spi_slave_rx #(
    parameter int BYTES_PER_WORD = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk,
    input  logic            cs_n,
    input  logic            mosi,
    spi_slave_rx_if.master  rx_if,
    output logic            overrun,
    output logic            frame_err,
    output logic            busy
);

    localparam int W   = 8 * BYTES_PER_WORD;
    localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int FCW = $clog2(SYNC_STAGES + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);
    localparam logic [FCW-1:0] FILL_DONE = FCW'(SYNC_STAGES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
    // Reverse the bit order of a byte. This turns an LSB-first byte into its true value.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction
`endif

    // ---------------------------------------------------------------- signals
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [FCW-1:0]         fill_cnt_q, fill_cnt_d;
    logic                   armed_q, armed_d;
    logic                   busy_q, busy_d;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [W-1:0]           shreg_q, shreg_d;

    logic [W-1:0]           rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic                   sclk_s;
    logic                   cs_n_s;
    logic                   mosi_s;
    logic                   rise_s;
    logic                   byte_done_s;
    logic                   word_done_s;
    logic                   handshake_s;
    logic [W-1:0]           shifted_s;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s      = cs_n_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign rise_s      = sclk_s & ~sclk_prev_q;
    assign byte_done_s = (bit_cnt_q == 3'd7);
    assign handshake_s = rx_valid_q & rx_if.rx_ready;

    // Synchronizer shift, edge history, post-reset arming and busy next-state
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        // busy mirrors the next synchronized cs_n. This keeps busy a flop
        // that stays exactly aligned with cs_n_s.
        busy_d      = ~cs_n_sync_d[SYNC_STAGES-1];

        // After reset the synchronizer outputs are reset values, not pin values.
        // Count until the pins have propagated through to the outputs.
        if (fill_cnt_q == FILL_DONE) begin
            fill_cnt_d = fill_cnt_q;
        end else begin
            fill_cnt_d = fill_cnt_q + FCW'(1);
        end

        // A frame already running when reset is released must be ignored.
        // Frames are accepted only after a real high level of cs_n is seen.
        if ((fill_cnt_q == FILL_DONE) && cs_n_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // Frame FSM, bit/byte counters and shift register next-state
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shreg_d     = shreg_q;
        word_done_s = 1'b0;
        frame_err_d = 1'b0;

        shifted_s = {shreg_q[W-2:0], mosi_s};
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
        shifted_s[7:0] = byte_done_s ? bit_rev8(shifted_s[7:0]) : shifted_s[7:0];
`endif

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d  = 3'd0;
                byte_cnt_d = {BCW{1'b0}};
                shreg_d    = {W{1'b0}};
                if (!cs_n_s && armed_q) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACTIVE: begin
                // Exit wins over a coincident sclk rise. The error check uses
                // the counters before any update.
                if (cs_n_s) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = 3'd0;
                    byte_cnt_d  = {BCW{1'b0}};
                    shreg_d     = {W{1'b0}};
                    frame_err_d = (bit_cnt_q != 3'd0) || (byte_cnt_q != {BCW{1'b0}});
                end else if (rise_s) begin
                    shreg_d   = shifted_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_done_s) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d  = {BCW{1'b0}};
                            word_done_s = 1'b1;
                        end else begin
                            byte_cnt_d  = byte_cnt_q + BCW'(1);
                            word_done_s = 1'b0;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = {BCW{1'b0}};
                shreg_d    = {W{1'b0}};
            end
        endcase
    end

    // Output buffer: load a completed word, or drop it and flag overrun
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;

        if (word_done_s) begin
            // A hand-off in the same cycle frees the buffer for the new word.
            if (!rx_valid_q || handshake_s) begin
                rx_data_d  = shifted_s;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end else if (handshake_s) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // Input synchronizer and arming registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            cs_n_sync_q <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_prev_q <= 1'b0;
            fill_cnt_q  <= {FCW{1'b0}};
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_n_sync_q <= cs_n_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            fill_cnt_q  <= fill_cnt_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
        end
    end

    // FSM, deserializer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= {BCW{1'b0}};
            shreg_q     <= {W{1'b0}};
            rx_data_q   <= {W{1'b0}};
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_if.rx_data  = rx_data_q;
    assign rx_if.rx_valid = rx_valid_q;
    assign overrun        = overrun_q;
    assign frame_err      = frame_err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
// Testbench for spi_slave_rx. It uses a scoreboard. The stimulus pushes the
// expected words and the expected pulses. A monitor checks them against the
// DUT outputs on the falling clk edge.
module tb_spi_slave_rx;
    localparam int W         = 32;
    localparam int SCLK_HALF = 40;   // 8 clk cycles per SCLK period

    logic clk;
    logic rst;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic overrun;
    logic frame_err;
    logic busy;

    spi_slave_rx_if #(.W(W)) rx_if();

    spi_slave_rx #(
        .BYTES_PER_WORD(4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .rx_if    (rx_if),
        .overrun  (overrun),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_word;
    int           exp_ovr     = 0;
    int           exp_ferr    = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_data: got unexpected word %h, expected none", rx_if.rx_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("rx_data", rx_if.rx_data, exp_word);
                end
            end
            if (overrun) begin
                vectors++;
                if (exp_ovr > 0) begin
                    exp_ovr--;
                end else begin
                    miscompares++;
                    $display("FAIL overrun: got pulse, expected none");
                end
            end
            if (frame_err) begin
                vectors++;
                if (exp_ferr > 0) begin
                    exp_ferr--;
                end else begin
                    miscompares++;
                    $display("FAIL frame_err: got pulse, expected none");
                end
            end
        end
    end

    // Map the k-th bit on the wire to its position in the word.
    function automatic int wire_bit_idx(input int k);
        int byte_i;
        int pos;
        byte_i = k / 8;
`ifdef SPI_SLAVE_RX_LSB_FIRST_EN
        pos = k % 8;
`else
        pos = 7 - (k % 8);
`endif
        return (3 - byte_i) * 8 + pos;
    endfunction

    task automatic send_bit(input logic b);
        mosi = b;
        #(SCLK_HALF);
        sclk = 1'b1;
        #(SCLK_HALF);
        sclk = 1'b0;
    endtask

    task automatic send_range(input logic [W-1:0] w, input int from, input int to);
        for (int k = from; k < to; k++) begin
            send_bit(w[wire_bit_idx(k)]);
        end
    endtask

    task automatic cs_assert();
        cs_n = 1'b0;
        #(2 * SCLK_HALF);
    endtask

    task automatic cs_release();
        #(2 * SCLK_HALF);
        cs_n = 1'b1;
        #(4 * SCLK_HALF);
    endtask

    task automatic send_frame(input logic [W-1:0] w);
        exp_q.push_back(w);
        cs_assert();
        send_range(w, 0, 32);
        cs_release();
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        logic [W-1:0] w;
        rst            = 1'b1;
        sclk           = 1'b0;
        cs_n           = 1'b1;
        mosi           = 1'b0;
        rx_if.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_if.rx_data, 32'h0000_0000);
        check("reset_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single word, consumer always ready
        send_frame(32'hA5C3_1E7F);
        check("valid_dropped", {31'd0, rx_if.rx_valid}, 32'd0);

        // Two words with the consumer stalled: the second word overruns
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b0;
        exp_q.push_back(32'h1122_3344);
        exp_ovr = 1;
        cs_assert();
        send_range(32'h1122_3344, 0, 32);
        send_range(32'h5566_7788, 0, 32);
        cs_release();
        check("valid_held", {31'd0, rx_if.rx_valid}, 32'd1);
        check("data_held", rx_if.rx_data, 32'h1122_3344);
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("valid_after_ready", {31'd0, rx_if.rx_valid}, 32'd0);

        // Truncated frame of 13 bits, then a good frame
        cs_assert();
        send_range(32'hF0F0_F0F0, 0, 13);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        exp_ferr = 1;
        cs_release();
        check("valid_after_ferr", {31'd0, rx_if.rx_valid}, 32'd0);
        send_frame(32'h1234_5678);

        // Reset asserted mid-frame
        w = 32'hCAFE_F00D;
        cs_assert();
        send_range(w, 0, 20);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_if.rx_data, 32'h0000_0000);
        check("rst_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_range(w, 20, 32);
        cs_release();
        send_frame(32'hDEAD_BEEF);

        // SCLK activity while cs_n is high is ignored
        for (int i = 0; i < 40; i++) begin
            send_bit(i[0]);
        end
        repeat (4) @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("valid_idle", {31'd0, rx_if.rx_valid}, 32'd0);

        // Byte pattern sensitive to the bit order within each byte
        send_frame(32'h0180_0FF0);

        // Drain and check that the scoreboard is empty
        repeat (20) @(negedge clk);
        check("words_pending", exp_q.size(), 32'd0);
        check("overrun_pending", exp_ovr, 32'd0);
        check("frame_err_pending", exp_ferr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
